// File: rtl/fpga_test_step_mul_acc_pipe.sv
// rtl/fpga_test_step_mul_acc_pipe.sv - pipelined multiplier with clock enable and multiply-accumulate
// Product is formed at the input and carried through NUM_STAGE-1 retimable registers into the accumulating output stage.
module fpga_test_step_mul_acc_pipe #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 15,
   parameter int din1_WIDTH  = 15,
   parameter int dout_WIDTH  = 30,
   parameter int din0_SIGNED = 0,
   parameter int din1_SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  acc_en,
   input  logic                  acc_clr,
   output logic                  out_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  acc_ovf
);

   localparam int PW         = din0_WIDTH + din1_WIDTH + 2;
   localparam bit ANY_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
   localparam int unused_id  = ID;

   logic                  a_sx;
   logic                  b_sx;
   logic signed [PW-1:0]  a_w;
   logic signed [PW-1:0]  b_w;
   logic signed [PW-1:0]  prod;

   logic [PW-1:0]         f_prod;
   logic                  f_valid;
   logic                  f_en;
   logic                  f_clr;

   logic [dout_WIDTH-1:0] prod_r;
   logic [dout_WIDTH-1:0] acc_q;
   logic [dout_WIDTH:0]   sum_x;
   logic                  wrap;

   // One extra bit per operand lets a single signed multiply serve every signedness mix.
   assign a_sx = (din0_SIGNED != 0) && din0[din0_WIDTH-1];
   assign b_sx = (din1_SIGNED != 0) && din1[din1_WIDTH-1];
   assign a_w  = PW'($signed({a_sx, din0}));
   assign b_w  = PW'($signed({b_sx, din1}));
   assign prod = a_w * b_w;

   generate
      if (NUM_STAGE == 1) begin : g_direct
         assign f_prod  = prod;
         assign f_valid = in_valid;
         assign f_en    = in_valid & acc_en;
         assign f_clr   = in_valid & acc_en & acc_clr;
      end else begin : g_pipe
         localparam int D = NUM_STAGE - 1;
         logic [PW-1:0] p_q [D];
         logic [D-1:0]  v_q;
         logic [D-1:0]  e_q;
         logic [D-1:0]  c_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < D; i++) p_q[i] <= '0;
               v_q <= '0;
               e_q <= '0;
               c_q <= '0;
            end else if (ce) begin
               p_q[0] <= prod;
               v_q[0] <= in_valid;
               e_q[0] <= in_valid & acc_en;
               c_q[0] <= in_valid & acc_en & acc_clr;
               for (int i = 1; i < D; i++) begin
                  p_q[i] <= p_q[i-1];
                  v_q[i] <= v_q[i-1];
                  e_q[i] <= e_q[i-1];
                  c_q[i] <= c_q[i-1];
               end
            end
         end

         assign f_prod  = p_q[D-1];
         assign f_valid = v_q[D-1];
         assign f_en    = e_q[D-1];
         assign f_clr   = c_q[D-1];
      end

      if (dout_WIDTH <= PW) begin : g_trunc
         assign prod_r = f_prod[dout_WIDTH-1:0];
         if (dout_WIDTH < PW) begin : g_drop
            logic unused_hi;
            assign unused_hi = ^f_prod[PW-1:dout_WIDTH];
         end
      end else begin : g_ext
         assign prod_r = ANY_SIGNED ? {{(dout_WIDTH-PW){f_prod[PW-1]}}, f_prod}
                                    : {{(dout_WIDTH-PW){1'b0}}, f_prod};
      end
   endgenerate

   assign sum_x = {1'b0, acc_q} + {1'b0, prod_r};
   assign wrap  = ANY_SIGNED ? ((acc_q[dout_WIDTH-1] == prod_r[dout_WIDTH-1]) &&
                                (sum_x[dout_WIDTH-1] != acc_q[dout_WIDTH-1]))
                             : sum_x[dout_WIDTH];

   // Accumulator exists only here, so back-to-back accumulate samples never see a stale value.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         dout      <= '0;
         acc_q     <= '0;
         acc_ovf   <= 1'b0;
      end else if (ce) begin
         out_valid <= f_valid;
         if (f_valid) begin
            if (!f_en) begin
               dout <= prod_r;
            end else if (f_clr) begin
               acc_q   <= prod_r;
               dout    <= prod_r;
               acc_ovf <= 1'b0;
            end else begin
               acc_q <= sum_x[dout_WIDTH-1:0];
               dout  <= sum_x[dout_WIDTH-1:0];
               if (wrap) acc_ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpga_test_step_mul_acc_pipe.sv
// tb/tb_fpga_test_step_mul_acc_pipe.sv - scoreboard bench for fpga_test_step_mul_acc_pipe
// Three instances (unsigned 30b, signed 30b, unsigned 8b) share one stimulus stream.
module tb_fpga_test_step_mul_acc_pipe;

   localparam int NS = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b1;
   logic        in_valid = 1'b0;
   logic [14:0] din0 = '0;
   logic [14:0] din1 = '0;
   logic        acc_en = 1'b0;
   logic        acc_clr = 1'b0;

   logic        ov_u, ov_s, ov_w;
   logic [29:0] dout_u, dout_s;
   logic [7:0]  dout_w;
   logic        ovf_u, ovf_s, ovf_w;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct { longint d; bit ovf; } exp_t;
   exp_t   q_u[$], q_s[$], q_w[$];
   longint acc_u = 0, acc_s = 0, acc_w = 0;
   bit     mo_u = 0, mo_s = 0, mo_w = 0;

   always #5 clk = ~clk;

   fpga_test_step_mul_acc_pipe #(.NUM_STAGE(NS)) dut_u (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_u), .dout(dout_u), .acc_ovf(ovf_u));

   fpga_test_step_mul_acc_pipe #(.NUM_STAGE(NS), .din0_SIGNED(1), .din1_SIGNED(1)) dut_s (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_s), .dout(dout_s), .acc_ovf(ovf_s));

   fpga_test_step_mul_acc_pipe #(.NUM_STAGE(NS), .dout_WIDTH(8)) dut_w (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_w), .dout(dout_w), .acc_ovf(ovf_w));

   function automatic void model(input longint p, input int w, input bit sgn, input bit en,
                                 input bit clr, inout longint acc, inout bit ovf, output exp_t e);
      longint m, half, pm, sum;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      pm   = p & m;
      if (!en) begin
         e.d = pm;
      end else if (clr) begin
         acc = pm;
         ovf = 1'b0;
         e.d = pm;
      end else begin
         if (sgn) begin
            sum = ((acc ^ half) - half) + ((pm ^ half) - half);
            if (sum >= half || sum < -half) ovf = 1'b1;
         end else begin
            sum = acc + pm;
            if (sum > m) ovf = 1'b1;
         end
         acc = sum & m;
         e.d = acc;
      end
      e.ovf = ovf;
   endfunction

   task automatic drive(input bit v, input logic [14:0] a, input logic [14:0] b,
                        input bit en, input bit clr);
      exp_t   e;
      longint pu, ps;
      in_valid = v;
      din0     = a;
      din1     = b;
      acc_en   = en;
      acc_clr  = clr;
      if (v && ce && !reset) begin
         pu = longint'(a) * longint'(b);
         ps = longint'($signed(a)) * longint'($signed(b));
         model(pu, 30, 1'b0, en, clr, acc_u, mo_u, e); q_u.push_back(e);
         model(ps, 30, 1'b1, en, clr, acc_s, mo_s, e); q_s.push_back(e);
         model(pu, 8,  1'b0, en, clr, acc_w, mo_w, e); q_w.push_back(e);
      end
   endtask

   // Scoreboard: every output produced on a live edge is matched against the oldest prediction.
   always @(posedge clk) begin
      bit   ce_e, rst_e;
      exp_t e;
      ce_e  = ce;
      rst_e = reset;
      #1;
      if (ce_e && !rst_e) begin
         if (ov_u) begin
            tests_run++;
            if (q_u.size() == 0) begin
               tests_failed++; $display("FAIL sb_u unexpected output dout=%0h", dout_u);
            end else begin
               e = q_u.pop_front();
               if (dout_u !== e.d[29:0] || ovf_u !== e.ovf) begin
                  tests_failed++;
                  $display("FAIL sb_u got dout=%0h ovf=%0b want dout=%0h ovf=%0b", dout_u, ovf_u, e.d[29:0], e.ovf);
               end
            end
         end
         if (ov_s) begin
            tests_run++;
            if (q_s.size() == 0) begin
               tests_failed++; $display("FAIL sb_s unexpected output dout=%0h", dout_s);
            end else begin
               e = q_s.pop_front();
               if (dout_s !== e.d[29:0] || ovf_s !== e.ovf) begin
                  tests_failed++;
                  $display("FAIL sb_s got dout=%0h ovf=%0b want dout=%0h ovf=%0b", dout_s, ovf_s, e.d[29:0], e.ovf);
               end
            end
         end
         if (ov_w) begin
            tests_run++;
            if (q_w.size() == 0) begin
               tests_failed++; $display("FAIL sb_w unexpected output dout=%0h", dout_w);
            end else begin
               e = q_w.pop_front();
               if (dout_w !== e.d[7:0] || ovf_w !== e.ovf) begin
                  tests_failed++;
                  $display("FAIL sb_w got dout=%0h ovf=%0b want dout=%0h ovf=%0b", dout_w, ovf_w, e.d[7:0], e.ovf);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({ov_u, ov_s, ov_w} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_valid got %b want 000", {ov_u, ov_s, ov_w});
      end
      tests_run++;
      if (dout_u !== 30'd0) begin
         tests_failed++; $display("FAIL reset_dout_u got %0h want 0", dout_u);
      end
      tests_run++;
      if (dout_s !== 30'd0 || dout_w !== 8'd0) begin
         tests_failed++; $display("FAIL reset_dout_sw got %0h/%0h want 0/0", dout_s, dout_w);
      end
      tests_run++;
      if ({ovf_u, ovf_s, ovf_w} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_ovf got %b want 000", {ovf_u, ovf_s, ovf_w});
      end
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic test_unsigned_max();
      int n = 0;
      bit got = 0;
      @(negedge clk) drive(1, 15'h7FFF, 15'h7FFF, 0, 0);
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); n++; #1;
         if (i == 0) drive(0, 0, 0, 0, 0);
         if (ov_u) got = 1;
      end
      tests_run++;
      if (!got || n != NS) begin
         tests_failed++; $display("FAIL t1_latency got %0d edges want %0d", n, NS);
      end
      tests_run++;
      if (dout_u !== 30'h3FFF0001) begin
         tests_failed++; $display("FAIL t1_dout got %0h want 3fff0001", dout_u);
      end
   endtask

   task automatic test_signed();
      bit got = 0;
      @(negedge clk) drive(1, 15'h7FFE, 15'd3, 0, 0);
      @(negedge clk) drive(1, 15'h4000, 15'h4000, 0, 0);
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         if (i == 0) drive(0, 0, 0, 0, 0);
         if (ov_s) got = 1;
      end
      tests_run++;
      if (!got || dout_s !== 30'h3FFFFFFA) begin
         tests_failed++; $display("FAIL t2_neg6 got %0h want 3ffffffa", dout_s);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ov_s !== 1'b1 || dout_s !== 30'h10000000) begin
         tests_failed++; $display("FAIL t2_minsq got v=%0b %0h want v=1 10000000", ov_s, dout_s);
      end
   endtask

   task automatic test_ce_stall();
      int n = 0;
      bit got = 0;
      @(negedge clk) begin ce = 1'b1; drive(1, 15'd5, 15'd7, 0, 0); end
      @(posedge clk); n++;
      @(negedge clk) begin ce = 1'b0; drive(0, 0, 0, 0, 0); end
      repeat (4) @(posedge clk);
      n += 4;
      #1;
      tests_run++;
      if (ov_u !== 1'b0) begin
         tests_failed++; $display("FAIL t3_early got out_valid=%0b want 0", ov_u);
      end
      @(negedge clk) ce = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); n++; #1;
         if (ov_u) got = 1;
      end
      tests_run++;
      if (!got || n != 7 || dout_u !== 30'd35) begin
         tests_failed++; $display("FAIL t3_out got clocks=%0d dout=%0d want 7/35", n, dout_u);
      end
      @(negedge clk) ce = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (ov_u !== 1'b1 || dout_u !== 30'd35) begin
         tests_failed++; $display("FAIL t3_hold got v=%0b dout=%0d want 1/35", ov_u, dout_u);
      end
      @(negedge clk) ce = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (ov_u !== 1'b0 || dout_u !== 30'd35) begin
         tests_failed++; $display("FAIL t3_bubble got v=%0b dout=%0d want 0/35", ov_u, dout_u);
      end
   endtask

   task automatic test_accumulate();
      logic [14:0] ta [3] = '{15'd2, 15'd4, 15'd1};
      logic [14:0] tb [3] = '{15'd3, 15'd5, 15'd1};
      logic [29:0] ex [3] = '{30'd6, 30'd26, 30'd27};
      int          cyc[$];
      logic [29:0] val[$];
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 3) drive(1, ta[c], tb[c], 1, c == 0);
         else       drive(0, 0, 0, 0, 0);
         @(posedge clk); #1;
         if (ov_u) begin cyc.push_back(c); val.push_back(dout_u); end
      end
      tests_run++;
      if (val.size() != 3) begin
         tests_failed++; $display("FAIL t4_count got %0d want 3", val.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (val[i] !== ex[i] || cyc[i] != NS - 1 + i) begin
               tests_failed++;
               $display("FAIL t4_seq%0d got %0d at cycle %0d want %0d at cycle %0d", i, val[i], cyc[i], ex[i], NS - 1 + i);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [14:0] ta [5] = '{15'd10, 15'd3, 15'd1, 15'd0, 15'd2};
      logic [14:0] tb [5] = '{15'd25, 15'd3, 15'd1, 15'd5, 15'd2};
      bit          te [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      bit          tc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [7:0]  ex [5] = '{8'd250, 8'd3, 8'd4, 8'd0, 8'd4};
      bit          eo [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0]  val[$];
      bit          ovv[$];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c < 5) drive(1, ta[c], tb[c], te[c], tc[c]);
         else       drive(0, 0, 0, 0, 0);
         @(posedge clk); #1;
         if (ov_w) begin val.push_back(dout_w); ovv.push_back(ovf_w); end
      end
      tests_run++;
      if (val.size() != 5) begin
         tests_failed++; $display("FAIL t5_count got %0d want 5", val.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (val[i] !== ex[i] || ovv[i] !== eo[i]) begin
               tests_failed++;
               $display("FAIL t5_seq%0d got dout=%0d ovf=%0b want dout=%0d ovf=%0b", i, val[i], ovv[i], ex[i], eo[i]);
            end
         end
      end
   endtask

   task automatic test_signed_wrap();
      logic [29:0] ex [3] = '{30'h10000000, 30'h20000000, 30'd1};
      bit          eo [3] = '{1'b0, 1'b1, 1'b0};
      logic [29:0] val[$];
      bit          ovv[$];
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 2)       drive(1, 15'h4000, 15'h4000, 1, c == 0);
         else if (c == 2) drive(1, 15'd1, 15'd1, 1, 1);
         else             drive(0, 0, 0, 0, 0);
         @(posedge clk); #1;
         if (ov_s) begin val.push_back(dout_s); ovv.push_back(ovf_s); end
      end
      tests_run++;
      if (val.size() != 3) begin
         tests_failed++; $display("FAIL sw_count got %0d want 3", val.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (val[i] !== ex[i] || ovv[i] !== eo[i]) begin
               tests_failed++;
               $display("FAIL sw_seq%0d got dout=%0h ovf=%0b want dout=%0h ovf=%0b", i, val[i], ovv[i], ex[i], eo[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      int seen = 0;
      @(negedge clk) drive(1, 15'd3, 15'd3, 1, 1);
      @(negedge clk) drive(1, 15'd4, 15'd4, 1, 0);
      @(negedge clk) begin
         reset = 1'b1;
         drive(1, 15'd5, 15'd5, 1, 0);
         q_u.delete(); q_s.delete(); q_w.delete();
         acc_u = 0; acc_s = 0; acc_w = 0;
         mo_u = 0; mo_s = 0; mo_w = 0;
      end
      @(negedge clk) begin reset = 1'b0; drive(0, 0, 0, 0, 0); end
      for (int c = 0; c < NS + 1; c++) begin
         @(posedge clk); #1;
         if (ov_u || ov_s || ov_w || dout_u !== 30'd0 || dout_s !== 30'd0 || dout_w !== 8'd0) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         tests_failed++; $display("FAIL t6_flush got %0d dirty cycles want 0", seen);
      end
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) drive(1, 15'd3, 15'd4, 1, 0);
         else        drive(0, 0, 0, 0, 0);
         @(posedge clk); #1;
         if (ov_u) begin
            seen++;
            tests_run++;
            if (dout_u !== 30'd12 || ovf_u !== 1'b0) begin
               tests_failed++; $display("FAIL t6_acc0 got dout=%0d ovf=%0b want 12/0", dout_u, ovf_u);
            end
         end
      end
      tests_run++;
      if (seen != 1) begin
         tests_failed++; $display("FAIL t6_count got %0d want 1", seen);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed();
      test_ce_stall();
      test_accumulate();
      test_wrap();
      test_signed_wrap();
      test_reset_midstream();
      repeat (NS + 2) @(posedge clk);
      #2;
      tests_run++;
      if (q_u.size() + q_s.size() + q_w.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_drain got %0d/%0d/%0d pending want 0", q_u.size(), q_s.size(), q_w.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
